mem_bus_arbiter: RTL and testbench

- Shares one SRAM-style memory bus between the pipeline's instruction-fetch port and data (MEM-stage) port.
- Supports one outstanding transaction at a time, using an address-phase/data-phase handshake.
- Produces stall requests that the hazard logic uses to freeze the fetch and memory stages.
- Sits between the datapath memory ports (pcF/instrF, aluoutM/writedataM/readdataM) and the external bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 13 +
 rtl/mem_bus_arbiter_req_mux.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared encodings for the fetch/data memory bus arbiter
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_WAIT = 2'd2
   } arbState_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_req_mux.sv
// rtl/mem_bus_arbiter_req_mux.sv - selects the address-phase fields of the winning requester
module arb_req_mux
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            sel,
   input  logic [AW-1:0]   instAddr,
   input  logic [AW-1:0]   dataAddr,
   input  logic [DW/8-1:0] dataWen,
   input  logic [DW-1:0]   dataWdata,
   output logic [AW-1:0]   addr,
   output logic [DW/8-1:0] wstrb,
   output logic [DW-1:0]   wdata
);

   // Fetches are always reads, so their strobes and write data are zero.
   assign addr  = (sel == OWN_DATA) ? dataAddr  : instAddr;
   assign wstrb = (sel == OWN_DATA) ? dataWen   : '0;
   assign wdata = (sel == OWN_DATA) ? dataWdata : '0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one SRAM-style bus between fetch and MEM-stage ports,
// one outstanding transaction, address-phase/data-phase handshake
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_req,
   input  logic [AW-1:0]   inst_addr,
   input  logic            inst_cancel,
   output logic [DW-1:0]   inst_rdata,
   output logic            inst_ok,
   input  logic            data_req,
   input  logic [DW/8-1:0] data_wen,
   input  logic [AW-1:0]   data_addr,
   input  logic [DW-1:0]   data_wdata,
   output logic [DW-1:0]   data_rdata,
   output logic            data_ok,
   output logic            bus_req,
   output logic [DW/8-1:0] bus_wstrb,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   input  logic            bus_addr_ok,
   input  logic [DW-1:0]   bus_rdata,
   input  logic            bus_data_ok,
   output logic            stall_f,
   output logic            stall_m
);

   arbState_t       state, stateNext;
   logic            owner, lastData, cancelPend;
   logic [AW-1:0]   addrQ;
   logic [DW/8-1:0] wstrbQ;
   logic [DW-1:0]   wdataQ;
   logic [DW-1:0]   instRdataQ, dataRdataQ;

   logic            anyReq, grantData;
   logic [AW-1:0]   muxAddr;
   logic [DW/8-1:0] muxWstrb;
   logic [DW-1:0]   muxWdata;
   logic            busReq;
   logic [AW-1:0]   busAddr;
   logic [DW/8-1:0] busWstrb;
   logic [DW-1:0]   busWdata;
   logic            complete, cancelHit, instOk, dataOk;

   // Data wins unless it also won last time and fetch is waiting.
   assign anyReq    = inst_req | data_req;
   assign grantData = data_req & (~inst_req | ~lastData);

   arb_req_mux #(.AW(AW), .DW(DW)) u_reqMux (
      .sel       (grantData),
      .instAddr  (inst_addr),
      .dataAddr  (data_addr),
      .dataWen   (data_wen),
      .dataWdata (data_wdata),
      .addr      (muxAddr),
      .wstrb     (muxWstrb),
      .wdata     (muxWdata)
   );

   always_comb begin
      stateNext = state;
      busReq    = 1'b0;
      busAddr   = '0;
      busWstrb  = '0;
      busWdata  = '0;
      case (state)
         S_IDLE: begin
            if (anyReq) begin
               busReq    = 1'b1;
               busAddr   = muxAddr;
               busWstrb  = muxWstrb;
               busWdata  = muxWdata;
               stateNext = bus_addr_ok ? S_WAIT : S_ADDR;
            end
         end
         S_ADDR: begin
            busReq   = 1'b1;
            busAddr  = addrQ;
            busWstrb = wstrbQ;
            busWdata = wdataQ;
            if (bus_addr_ok) stateNext = S_WAIT;
         end
         S_WAIT: begin
            if (bus_data_ok) stateNext = S_IDLE;
         end
         default: stateNext = S_IDLE;
      endcase
   end

   // A cancel landing on the completion cycle itself also suppresses the fetch.
   assign cancelHit = inst_cancel & (owner == OWN_INST) & (state != S_IDLE);
   assign complete  = rst & (state == S_WAIT) & bus_data_ok;
   assign instOk    = complete & (owner == OWN_INST) & ~(cancelPend | cancelHit);
   assign dataOk    = complete & (owner == OWN_DATA);

   // Reset forces every output low even while requests are still asserted.
   assign bus_req    = rst & busReq;
   assign bus_addr   = rst ? busAddr  : '0;
   assign bus_wstrb  = rst ? busWstrb : '0;
   assign bus_wdata  = rst ? busWdata : '0;
   assign inst_ok    = instOk;
   assign data_ok    = dataOk;
   assign inst_rdata = instOk ? bus_rdata : instRdataQ;
   assign data_rdata = dataOk ? bus_rdata : dataRdataQ;
   assign stall_f    = rst & inst_req & ~instOk;
   assign stall_m    = rst & data_req & ~dataOk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         owner      <= OWN_INST;
         lastData   <= 1'b0;
         cancelPend <= 1'b0;
         addrQ      <= '0;
         wstrbQ     <= '0;
         wdataQ     <= '0;
         instRdataQ <= '0;
         dataRdataQ <= '0;
      end else begin
         state <= stateNext;
         if (state == S_IDLE && anyReq) begin
            owner  <= grantData;
            addrQ  <= muxAddr;
            wstrbQ <= muxWstrb;
            wdataQ <= muxWdata;
         end
         if (cancelHit) cancelPend <= 1'b1;
         if (complete) begin
            lastData   <= owner;
            cancelPend <= 1'b0;
         end
         if (instOk) instRdataQ <= bus_rdata;
         if (dataOk) dataRdataQ <= bus_rdata;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            inst_req, inst_cancel, inst_ok;
   logic [AW-1:0]   inst_addr;
   logic [DW-1:0]   inst_rdata;
   logic            data_req, data_ok;
   logic [DW/8-1:0] data_wen;
   logic [AW-1:0]   data_addr;
   logic [DW-1:0]   data_wdata, data_rdata;
   logic            bus_req, bus_addr_ok, bus_data_ok;
   logic [DW/8-1:0] bus_wstrb;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_wdata, bus_rdata;
   logic            stall_f, stall_m;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_cancel (inst_cancel),
      .inst_rdata  (inst_rdata),
      .inst_ok     (inst_ok),
      .data_req    (data_req),
      .data_wen    (data_wen),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_rdata  (data_rdata),
      .data_ok     (data_ok),
      .bus_req     (bus_req),
      .bus_wstrb   (bus_wstrb),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_addr_ok (bus_addr_ok),
      .bus_rdata   (bus_rdata),
      .bus_data_ok (bus_data_ok),
      .stall_f     (stall_f),
      .stall_m     (stall_m)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      inst_req = 1'b1; inst_addr = 32'hBFC00000; inst_cancel = 1'b0;
      data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
      bus_addr_ok = 1'b0; bus_rdata = '0; bus_data_ok = 1'b0;

      // Reset with both requests up: all outputs low
      #2;
      checkVal("rst_bus_req",    bus_req,    0);
      checkVal("rst_bus_addr",   bus_addr,   0);
      checkVal("rst_bus_wstrb",  bus_wstrb,  0);
      checkVal("rst_bus_wdata",  bus_wdata,  0);
      checkVal("rst_inst_ok",    inst_ok,    0);
      checkVal("rst_data_ok",    data_ok,    0);
      checkVal("rst_stall_f",    stall_f,    0);
      checkVal("rst_stall_m",    stall_m,    0);
      checkVal("rst_inst_rdata", inst_rdata, 0);
      checkVal("rst_data_rdata", data_rdata, 0);
      tick;
      inst_req = 1'b0; data_req = 1'b0;
      tick;
      rst = 1'b1;
      #2;
      checkVal("idle_bus_req", bus_req, 0);

      // Lone fetch, zero-wait bus
      tick;
      inst_req = 1'b1; inst_addr = 32'hBFC00000; bus_addr_ok = 1'b1;
      #2;
      checkVal("f1_bus_req",  bus_req,   1);
      checkVal("f1_bus_addr", bus_addr,  32'hBFC00000);
      checkVal("f1_wstrb",    bus_wstrb, 0);
      checkVal("f1_stall_f",  stall_f,   1);
      checkVal("f1_inst_ok0", inst_ok,   0);
      tick;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24080001;
      #2;
      checkVal("f1_bus_req_wait", bus_req,    0);
      checkVal("f1_inst_ok",      inst_ok,    1);
      checkVal("f1_inst_rdata",   inst_rdata, 32'h24080001);
      checkVal("f1_stall_f_done", stall_f,    0);
      tick;
      inst_req = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      #2;
      checkVal("f1_ok_pulse",   inst_ok,    0);
      checkVal("f1_rdata_held", inst_rdata, 32'h24080001);

      // Simultaneous requests: data first, then pending fetch beats a new data request
      tick;
      inst_req = 1'b1; inst_addr = 32'hBFC00004;
      data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
      bus_addr_ok = 1'b1;
      #2;
      checkVal("sim_bus_addr", bus_addr,  32'h80000010);
      checkVal("sim_wstrb",    bus_wstrb, 4'hF);
      checkVal("sim_wdata",    bus_wdata, 32'hDEADBEEF);
      checkVal("sim_stall_f",  stall_f,   1);
      checkVal("sim_stall_m",  stall_m,   1);
      tick;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      #2;
      checkVal("sim_data_ok", data_ok, 1);
      checkVal("sim_inst_ok", inst_ok, 0);
      checkVal("sim_stall_m_done", stall_m, 0);
      tick;
      bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
      data_wen = 4'h0; data_addr = 32'h80000020; data_wdata = '0;
      #2;
      checkVal("fair_bus_addr", bus_addr,  32'hBFC00004);
      checkVal("fair_wstrb",    bus_wstrb, 0);
      checkVal("fair_stall_m",  stall_m,   1);
      tick;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA5555;
      #2;
      checkVal("fair_inst_ok",    inst_ok,    1);
      checkVal("fair_inst_rdata", inst_rdata, 32'hAAAA5555);
      checkVal("fair_data_ok",    data_ok,    0);

      // Data store with address phase stalled three cycles
      tick;
      inst_req = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      data_wen = 4'h3; data_addr = 32'h80000020; data_wdata = 32'h11223344;
      #2;
      checkVal("adr_grant_addr", bus_addr,  32'h80000020);
      checkVal("adr_grant_req",  bus_req,   1);
      tick;
      data_addr = 32'hFFFFFFFF; data_wen = 4'hC; data_wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         #2;
         checkVal("adr_hold_req",   bus_req,   1);
         checkVal("adr_hold_addr",  bus_addr,  32'h80000020);
         checkVal("adr_hold_wstrb", bus_wstrb, 4'h3);
         checkVal("adr_hold_wdata", bus_wdata, 32'h11223344);
         checkVal("adr_hold_stall", stall_m,   1);
         tick;
      end
      bus_addr_ok = 1'b1;
      #2;
      checkVal("adr_accept_req", bus_req, 1);
      tick;
      bus_addr_ok = 1'b0;
      #2;
      checkVal("adr_wait_req",   bus_req, 0);
      checkVal("adr_wait_stall", stall_m, 1);
      checkVal("adr_wait_ok",    data_ok, 0);
      tick;
      bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
      #2;
      checkVal("adr_data_ok",    data_ok,    1);
      checkVal("adr_data_rdata", data_rdata, 32'hCAFEF00D);
      tick;
      data_req = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

      // Fetch cancelled while waiting for data
      inst_req = 1'b1; inst_addr = 32'hBFC00008; bus_addr_ok = 1'b1;
      #2;
      checkVal("can_bus_req", bus_req, 1);
      tick;
      bus_addr_ok = 1'b0; inst_cancel = 1'b1; inst_req = 1'b0;
      #2;
      checkVal("can_inst_ok_a", inst_ok, 0);
      tick;
      inst_cancel = 1'b0;
      #2;
      checkVal("can_wait_req", bus_req, 0);
      tick;
      bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
      #2;
      checkVal("can_inst_ok",    inst_ok,    0);
      checkVal("can_inst_rdata", inst_rdata, 32'hAAAA5555);
      tick;
      bus_data_ok = 1'b0; bus_rdata = '0;
      inst_req = 1'b1; inst_addr = 32'hBFC0000C; bus_addr_ok = 1'b1;
      #2;
      checkVal("can_next_req",  bus_req,  1);
      checkVal("can_next_addr", bus_addr, 32'hBFC0000C);
      tick;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BADF00D;
      #2;
      checkVal("can_next_ok",    inst_ok,    1);
      checkVal("can_next_rdata", inst_rdata, 32'h0BADF00D);
      tick;
      inst_req = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

      // Asynchronous reset during a data WAIT
      data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h00000008; bus_addr_ok = 1'b1;
      tick;
      bus_addr_ok = 1'b0;
      #2;
      checkVal("ar_pre_rdata", data_rdata, 32'hCAFEF00D);
      rst = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'h55555555;
      #1;
      checkVal("ar_stall_m",    stall_m,    0);
      checkVal("ar_data_ok",    data_ok,    0);
      checkVal("ar_data_rdata", data_rdata, 0);
      checkVal("ar_inst_rdata", inst_rdata, 0);
      checkVal("ar_bus_req",    bus_req,    0);
      tick;
      data_req = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      tick;
      rst = 1'b1;
      tick;
      data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h00000004; bus_addr_ok = 1'b1;
      #2;
      checkVal("ar_new_req",   bus_req,   1);
      checkVal("ar_new_addr",  bus_addr,  32'h00000004);
      checkVal("ar_new_wstrb", bus_wstrb, 0);
      tick;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000FFFF;
      #2;
      checkVal("ar_new_ok",    data_ok,    1);
      checkVal("ar_new_rdata", data_rdata, 32'h0000FFFF);
      tick;
      data_req = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

      // Spurious data-phase strobe while idle
      bus_data_ok = 1'b1; bus_rdata = 32'h77777777;
      #2;
      checkVal("sp_inst_ok",    inst_ok,    0);
      checkVal("sp_data_ok",    data_ok,    0);
      checkVal("sp_bus_req",    bus_req,    0);
      checkVal("sp_data_rdata", data_rdata, 32'h0000FFFF);
      tick;
      bus_data_ok = 1'b0; bus_rdata = '0;
      inst_req = 1'b1; inst_addr = 32'hBFC00010; bus_addr_ok = 1'b1;
      #2;
      checkVal("sp_next_req",  bus_req,  1);
      checkVal("sp_next_addr", bus_addr, 32'hBFC00010);
      tick;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C1DBFC0;
      #2;
      checkVal("sp_next_ok",    inst_ok,    1);
      checkVal("sp_next_rdata", inst_rdata, 32'h3C1DBFC0);
      tick;
      inst_req = 1'b0; bus_data_ok = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
